// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default width for the sequential divider
package div_pkg;
  typedef enum logic {DIV_IDLE = 1'b0, DIV_RUN = 1'b1} div_state_e;
  localparam int DIV_WIDTH = 32;
endpackage

// File: rtl/seq_restoring_divider_step.sv
// div_step: one restoring-division iteration (shift in dividend bit, trial subtract, restore)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  always_comb begin
    t = {rem_in, quo_msb};
    {borrow, diff} = {1'b0, t[WIDTH-1:0]} - {1'b0, divisor};
    q_bit = t[WIDTH] | ~borrow;
    rem_out = q_bit ? diff : t[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);
  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] d_reg, rem_reg, quo_reg, rem_nxt, quo_nxt;
  logic [CNT_W-1:0] cnt;
  logic             q_bit, last, accept, zero_div;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_reg),
    .quo_msb(quo_reg[WIDTH-1]),
    .divisor(d_reg),
    .rem_out(rem_nxt),
    .q_bit  (q_bit)
  );
  assign quo_nxt  = {quo_reg[WIDTH-2:0], q_bit};
  assign last     = cnt == CNT_W'(1);
  assign accept   = state == DIV_IDLE && start;
  assign zero_div = divisor == '0;
  always_ff @(posedge clk) state <= reset ? DIV_IDLE : state_nxt;
  always_comb state_nxt = state == DIV_IDLE ? (accept && !zero_div ? DIV_RUN : DIV_IDLE)
                                            : (last ? DIV_IDLE : DIV_RUN);
  always_comb busy = state == DIV_RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      d_reg       <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      if (accept && zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end else if (accept) begin
        d_reg   <= divisor;
        rem_reg <= '0;
        quo_reg <= dividend;
        cnt     <= CNT_W'(WIDTH);
      end else if (state == DIV_RUN) begin
        rem_reg <= rem_nxt;
        quo_reg <= quo_nxt;
        cnt     <= cnt - CNT_W'(1);
        if (last) begin
          quotient    <= quo_nxt;
          remainder   <= rem_nxt;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: randomized self-checking bench against an arithmetic reference model
module tb_seq_restoring_divider;
  logic clk = 1'b0, reset = 1'b1;
  logic start8 = 0, done8, busy8, dz8;
  logic [7:0] dd8 = 0, dv8 = 0, q8, r8;
  logic start16 = 0, done16, busy16, dz16;
  logic [15:0] dd16 = 0, dv16 = 0, q16, r16;
  logic start32 = 0, done32, busy32, dz32;
  logic [31:0] dd32 = 0, dv32 = 0, q32, r32;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  seq_restoring_divider #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .dividend(dd8), .divisor(dv8),
    .quotient(q8), .remainder(r8), .done(done8), .busy(busy8), .div_by_zero(dz8));
  seq_restoring_divider #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .dividend(dd16), .divisor(dv16),
    .quotient(q16), .remainder(r16), .done(done16), .busy(busy16), .div_by_zero(dz16));
  seq_restoring_divider #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .dividend(dd32), .divisor(dv32),
    .quotient(q32), .remainder(r32), .done(done32), .busy(busy32), .div_by_zero(dz32));
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int edges,
                      output int busy_n, output logic [7:0] q, output logic [7:0] r, output logic dz);
    start8 = 1; dd8 = a; dv8 = b; edges = -1; busy_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start8 = 0; dd8 = 8'($urandom); dv8 = 8'($urandom);
      if (busy8) busy_n++;
      if (done8) begin edges = c - 1; break; end
    end
    q = q8; r = r8; dz = dz8;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    @(negedge clk);
    n_cmp++; if ({q8, r8} !== 16'h0) begin n_fail++; $display("FAIL reset_qr got q=%0d r=%0d want 0 0", q8, r8); end
    n_cmp++; if ({done8, busy8, dz8} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got done/busy/dz=%b want 000", {done8, busy8, dz8}); end
  endtask
  task automatic test_basic;
    int e, bn; logic [7:0] q, r; logic dz;
    run8(8'd200, 8'd7, e, bn, q, r, dz);
    n_cmp++; if (e !== 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", e); end
    n_cmp++; if (bn !== 8) begin n_fail++; $display("FAIL basic_busy got %0d want 8", bn); end
    n_cmp++; if (q !== 8'd28) begin n_fail++; $display("FAIL basic_q got %0d want 28", q); end
    n_cmp++; if (r !== 8'd4) begin n_fail++; $display("FAIL basic_r got %0d want 4", r); end
    n_cmp++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz got %b want 0", dz); end
    @(negedge clk);
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done8); end
  endtask
  task automatic test_div_zero;
    int e, bn; logic [7:0] q, r; logic dz;
    run8(8'd45, 8'd0, e, bn, q, r, dz);
    n_cmp++; if (e !== 0) begin n_fail++; $display("FAIL dz_latency got %0d want 0", e); end
    n_cmp++; if (bn !== 0) begin n_fail++; $display("FAIL dz_busy got %0d want 0", bn); end
    n_cmp++; if ({q, r, dz} !== {8'd255, 8'd45, 1'b1}) begin n_fail++; $display("FAIL dz_result got q=%0d r=%0d dz=%b want 255 45 1", q, r, dz); end
    @(negedge clk);
    n_cmp++; if ({done8, busy8} !== 2'b00) begin n_fail++; $display("FAIL dz_after got done/busy=%b want 00", {done8, busy8}); end
  endtask
  task automatic test_msb32;
    int e = -1;
    start32 = 1; dd32 = 32'hFFFF_FFFF; dv32 = 32'h8000_0001;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      start32 = 0; dd32 = $urandom; dv32 = $urandom;
      if (done32) begin e = c - 1; break; end
    end
    n_cmp++; if (e !== 32) begin n_fail++; $display("FAIL msb32_latency got %0d want 32", e); end
    n_cmp++; if (q32 !== 32'd1) begin n_fail++; $display("FAIL msb32_q got %h want 00000001", q32); end
    n_cmp++; if (r32 !== 32'h7FFF_FFFE) begin n_fail++; $display("FAIL msb32_r got %h want 7ffffffe", r32); end
  endtask
  task automatic test_back_to_back;
    int e1 = -1, e2, bn; logic [7:0] q1, r1, q, r; logic dz;
    start8 = 1; dd8 = 8'd100; dv8 = 8'd9;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start8 = c == 3; dd8 = 8'd50; dv8 = 8'd5;
      if (done8) begin e1 = c - 1; break; end
    end
    q1 = q8; r1 = r8;
    run8(8'd50, 8'd5, e2, bn, q, r, dz);
    n_cmp++; if (e1 !== 8) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 8", e1); end
    n_cmp++; if ({q1, r1} !== {8'd11, 8'd1}) begin n_fail++; $display("FAIL b2b_first got q=%0d r=%0d want 11 1", q1, r1); end
    n_cmp++; if (e2 !== 8) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 8", e2); end
    n_cmp++; if ({q, r} !== {8'd10, 8'd0}) begin n_fail++; $display("FAIL b2b_second got q=%0d r=%0d want 10 0", q, r); end
    @(negedge clk);
  endtask
  task automatic test_reset_abort;
    int e, bn, pulses = 0; logic [7:0] q, r; logic dz;
    start8 = 1; dd8 = 8'd200; dv8 = 8'd7;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start8 = 0;
      if (c == 4) reset = 1;
    end
    @(negedge clk); reset = 0;
    n_cmp++; if ({q8, r8, done8, busy8, dz8} !== 19'h0) begin n_fail++; $display("FAIL abort_outputs got q=%0d r=%0d done/busy/dz=%b want all 0", q8, r8, {done8, busy8, dz8}); end
    repeat (12) begin @(negedge clk); if (done8) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
    run8(8'd9, 8'd3, e, bn, q, r, dz);
    n_cmp++; if ({q, r, e} !== {8'd3, 8'd0, 32'd8}) begin n_fail++; $display("FAIL abort_next got q=%0d r=%0d lat=%0d want 3 0 8", q, r, e); end
  endtask
  task automatic test_random;
    logic [15:0] a, b, eq, er;
    int e;
    for (int i = 0; i < 3000; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      case (i % 6)
        0: b = 16'd1;
        1: begin a = 16'($urandom_range(0, 1000)); b = a + 16'($urandom_range(1, 1000)); end
        2: a = '0;
        3: b = '0;
        4: b[15] = 1'b1;
        default: ;
      endcase
      eq = b == 0 ? 16'hFFFF : a / b;
      er = b == 0 ? a : a % b;
      start16 = 1; dd16 = a; dv16 = b; e = -1;
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        start16 = 0; dd16 = 16'($urandom); dv16 = 16'($urandom);
        if (done16) begin e = c - 1; break; end
      end
      n_cmp++; if (e !== (b == 0 ? 0 : 16)) begin n_fail++; $display("FAIL rand_latency %0d/%0d got %0d", a, b, e); end
      n_cmp++; if (q16 !== eq) begin n_fail++; $display("FAIL rand_q %0d/%0d got %0d want %0d", a, b, q16, eq); end
      n_cmp++; if (r16 !== er) begin n_fail++; $display("FAIL rand_r %0d/%0d got %0d want %0d", a, b, r16, er); end
      n_cmp++; if (dz16 !== (b == 0)) begin n_fail++; $display("FAIL rand_dz %0d/%0d got %b", a, b, dz16); end
    end
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_basic;
    test_div_zero;
    test_msb32;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
